// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Function : Packs a byte stream little-endian into 32-bit words and writes
//            them sequentially into the instruction memory, holding the CPU
//            in reset while loading. Optional checksum byte when the macro
//            IMEM_LOADER_CKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter  int DEPTH       = 16,
  parameter  int TIMEOUT_CYC = 1000000,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          cpu_rst_n,
  output logic [AW:0]   words_loaded
);

  localparam int            IW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic          rx_ready_q, rx_ready_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_waddr_q, mem_waddr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic [AW:0]   words_loaded_q, words_loaded_d;
  logic [AW:0]   nwords_q, nwords_d;
  logic [AW:0]   widx_q, widx_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   buf_q, buf_d;
  logic [IW-1:0] idle_q, idle_d;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  logic          w_accept;
  logic          w_abort;
  logic          w_finish;
  logic [AW:0]   w_widx_inc;

  assign w_accept   = rx_valid && rx_ready_q;
  assign w_widx_inc = widx_q + (AW+1)'(1);

  always_comb begin
    state_d        = state_q;
    rx_ready_d     = 1'b0;
    mem_we_d       = 1'b0;
    mem_waddr_d    = mem_waddr_q;
    mem_wdata_d    = mem_wdata_q;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    error_d        = error_q;
    cpu_rst_n_d    = cpu_rst_n_q;
    words_loaded_d = words_loaded_q + (AW+1)'(mem_we_q);
    nwords_d       = nwords_q;
    widx_d         = widx_q;
    byte_cnt_d     = byte_cnt_q;
    buf_d          = buf_q;
    idle_d         = w_accept ? '0 : idle_q + IW'(1);
    w_abort        = 1'b0;
    w_finish       = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    sum_d          = w_accept ? sum_q + rx_data : sum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        idle_d      = '0;
        cpu_rst_n_d = (state_q != S_ERROR);
        if (start) begin
          state_d        = S_COUNT;
          rx_ready_d     = 1'b1;
          busy_d         = 1'b1;
          cpu_rst_n_d    = 1'b0;
          error_d        = 1'b0;
          words_loaded_d = '0;
          widx_d         = '0;
          byte_cnt_d     = '0;
`ifdef IMEM_LOADER_CKSUM_EN
          sum_d          = '0;
`endif
        end
      end

      S_COUNT: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
        if (w_accept) begin
          if (rx_data == 8'd0 || int'(rx_data) > DEPTH) begin
            w_abort = 1'b1;
          end else begin
            nwords_d = (AW+1)'(rx_data);
            state_d  = S_DATA;
          end
        end else if (idle_q == IDLE_LAST) begin
          w_abort = 1'b1;
        end
      end

      S_DATA: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
        if (w_accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Shift in from the top so byte 0 lands in bits [7:0] after three bytes.
          buf_d      = {rx_data, buf_q[23:8]};
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = widx_q[AW-1:0];
            mem_wdata_d = {rx_data, buf_q};
            widx_d      = w_widx_inc;
            if (w_widx_inc == nwords_q) begin
`ifdef IMEM_LOADER_CKSUM_EN
              state_d    = S_CHECK;
`else
              rx_ready_d = 1'b0;
`endif
            end
          end
        end else if (widx_q == nwords_q) begin
          // Final word is on the write port this cycle.
          w_finish = 1'b1;
        end else if (idle_q == IDLE_LAST) begin
          w_abort = 1'b1;
        end
      end

`ifdef IMEM_LOADER_CKSUM_EN
      S_CHECK: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
        if (w_accept) begin
          if (rx_data == sum_q) w_finish = 1'b1;
          else                  w_abort  = 1'b1;
        end else if (idle_q == IDLE_LAST) begin
          w_abort = 1'b1;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    if (w_abort) begin
      state_d     = S_ERROR;
      error_d     = 1'b1;
      rx_ready_d  = 1'b0;
      busy_d      = 1'b0;
      cpu_rst_n_d = 1'b0;
    end
    if (w_finish) begin
      state_d     = S_DONE;
      done_d      = 1'b1;
      rx_ready_d  = 1'b0;
      busy_d      = 1'b0;
      cpu_rst_n_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rx_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_waddr_q    <= '0;
      mem_wdata_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      cpu_rst_n_q    <= 1'b0;
      words_loaded_q <= '0;
      nwords_q       <= '0;
      widx_q         <= '0;
      byte_cnt_q     <= '0;
      buf_q          <= '0;
      idle_q         <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rx_ready_q     <= rx_ready_d;
      mem_we_q       <= mem_we_d;
      mem_waddr_q    <= mem_waddr_d;
      mem_wdata_q    <= mem_wdata_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      cpu_rst_n_q    <= cpu_rst_n_d;
      words_loaded_q <= words_loaded_d;
      nwords_q       <= nwords_d;
      widx_q         <= widx_d;
      byte_cnt_q     <= byte_cnt_d;
      buf_q          <= buf_d;
      idle_q         <= idle_d;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q          <= sum_d;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_waddr    = mem_waddr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign words_loaded = words_loaded_q;

endmodule
`default_nettype wire
